// File: rtl/sw_pkg.sv
// Shared constants and width helpers for the multi-channel switch debouncer.
package sw_pkg;

    // Bits needed to hold the values 0..n-1 (never less than 1).
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int DEF_PERIOD      = 65536;
    localparam int DEF_STABLE      = 3;
    localparam int DEF_REPEAT_DLY  = 50;
    localparam int DEF_REPEAT_RATE = 10;

    localparam int DEF_PCNT_W = clog2(DEF_PERIOD);
    localparam int DEF_SCNT_W = clog2(DEF_STABLE + 1);
    localparam int DEF_HCNT_W = clog2(DEF_REPEAT_DLY + 2);
    localparam int DEF_RCNT_W = clog2(DEF_REPEAT_RATE);

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: two-flop synchroniser, stability counter, edge pulses
// and auto-repeat scheduling driven by the shared sample tick.
module sw_debounce_ch
    import sw_pkg::*;
#(
    parameter int STABLE      = DEF_STABLE,
    parameter int REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
    input  logic CLK,
    input  logic RST,
    input  logic tick,
    input  logic raw,
    input  logic invert,
    input  logic repeat_en,
    output logic level,
    output logic rise,
    output logic fall,
    output logic press
);

    localparam int SCNT_W = clog2(STABLE + 1);
    localparam int HCNT_W = clog2(REPEAT_DLY + 2);
    localparam int RCNT_W = clog2(REPEAT_RATE);

    // Saturating at all-ones keeps hcnt above REPEAT_DLY once reached.
    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;

    logic              s1, s2;
    logic [SCNT_W-1:0] scnt;
    logic [HCNT_W-1:0] hcnt;
    logic [RCNT_W-1:0] rcnt;
    logic              flip;
    logic              rep_evt;

    assign flip    = tick && (s2 != level) && (scnt == SCNT_W'(STABLE - 1));
    assign rep_evt = level && tick &&
                     ((hcnt == HCNT_W'(REPEAT_DLY)) ||
                      ((hcnt > HCNT_W'(REPEAT_DLY)) && (rcnt == '0)));
    // repeat_en is applied combinationally so a deassert masks the very next event.
    assign press   = rise || (repeat_en && rep_evt);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flip-flops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            scnt  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            hcnt  <= '0;
            rcnt  <= '0;
        end else begin
            s1   <= raw ^ invert;
            s2   <= s1;
            rise <= flip && !level;
            fall <= flip && level;

            if (tick) begin
                if (s2 != level) begin
                    if (flip) begin
                        level <= ~level;
                        scnt  <= '0;
                    end else begin
                        scnt <= scnt + SCNT_W'(1);
                    end
                end else begin
                    scnt <= '0;
                end
            end

            if (flip) begin
                hcnt <= '0;
                rcnt <= '0;
            end else if (tick && level) begin
                if (hcnt != HCNT_MAX) hcnt <= hcnt + HCNT_W'(1);
                // Reload down-counter replaces (hcnt - REPEAT_DLY) % REPEAT_RATE.
                if (hcnt == HCNT_W'(REPEAT_DLY))
                    rcnt <= RCNT_W'(REPEAT_RATE - 1);
                else if (hcnt > HCNT_W'(REPEAT_DLY))
                    rcnt <= (rcnt == '0) ? RCNT_W'(REPEAT_RATE - 1) : rcnt - RCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce_multi.sv
// Multi-channel switch debouncer: shared sample-tick prescaler feeding
// N_CH independent debounce/one-shot/auto-repeat channels.
module sw_debounce_multi
    import sw_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              PERIOD      = DEF_PERIOD,
    parameter int              STABLE      = DEF_STABLE,
    parameter int              REPEAT_DLY  = DEF_REPEAT_DLY,
    parameter int              REPEAT_RATE = DEF_REPEAT_RATE,
    parameter logic [N_CH-1:0] INVERT      = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] sw_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] press,
    output logic            tick
);

    localparam int PCNT_W = clog2(PERIOD);

    logic [PCNT_W-1:0] pcnt;
    logic              wrap;

    assign wrap = (pcnt == PCNT_W'(PERIOD - 1));

    // NOTE: reset is asynchronous, so outputs clear the moment RST falls,
    // without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            pcnt <= wrap ? '0 : pcnt + PCNT_W'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sw_debounce_ch #(
            .STABLE      (STABLE),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .CLK       (CLK),
            .RST       (RST),
            .tick      (tick),
            .raw       (sw_in[i]),
            .invert    (INVERT[i]),
            .repeat_en (repeat_en[i]),
            .level     (level[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .press     (press[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce_multi.sv
// Self-checking bench for sw_debounce_multi: vector table, directed corner
// sequences and random stimulus against a sample-window reference model.
module tb_sw_debounce_multi;

    localparam int         NC   = 4;
    localparam int         PER  = 4;
    localparam int         STB  = 3;
    localparam int         DLY  = 5;
    localparam int         RATE = 2;
    localparam logic [3:0] INV  = 4'b1000;

    logic          CLK, RST;
    logic [NC-1:0] sw_in, repeat_en;
    logic [NC-1:0] level, rise, fall, press;
    logic          tick;

    sw_debounce_multi #(
        .N_CH(NC), .PERIOD(PER), .STABLE(STB),
        .REPEAT_DLY(DLY), .REPEAT_RATE(RATE), .INVERT(INV)
    ) dut (
        .CLK(CLK), .RST(RST), .sw_in(sw_in), .repeat_en(repeat_en),
        .level(level), .rise(rise), .fall(fall), .press(press), .tick(tick)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level flips once the last STB tick samples taken
    // since the previous flip all disagree with it; held counts ticks since rise.
    int         edges;
    logic [3:0] m_s1, m_s2, m_level, m_rise, m_fall;
    logic       m_tick;
    int         held [NC];
    bit         hist [NC][$];
    bit         m_flip, m_diff;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edges = 0;
            m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
            m_tick = 1'b0;
            for (int ch = 0; ch < NC; ch++) begin
                held[ch] = 0;
                hist[ch].delete();
            end
        end else begin
            edges++;
            for (int ch = 0; ch < NC; ch++) begin
                m_rise[ch] = 1'b0;
                m_fall[ch] = 1'b0;
                m_flip = 1'b0;
                if (m_tick) begin
                    hist[ch].push_back(m_s2[ch]);
                    if (hist[ch].size() > STB) void'(hist[ch].pop_front());
                    if (hist[ch].size() == STB) begin
                        m_diff = 1'b1;
                        for (int k = 0; k < hist[ch].size(); k++)
                            if (hist[ch][k] == m_level[ch]) m_diff = 1'b0;
                        m_flip = m_diff;
                    end
                end
                if (m_flip) begin
                    hist[ch].delete();
                    m_rise[ch]  = !m_level[ch];
                    m_fall[ch]  = m_level[ch];
                    m_level[ch] = !m_level[ch];
                    held[ch]    = 0;
                end else if (m_tick && m_level[ch]) begin
                    held[ch]++;
                end
            end
            m_s2   = m_s1;
            m_s1   = sw_in ^ INV;
            m_tick = (edges % PER == 0);
        end
    end

    function automatic logic [3:0] model_press();
        logic [3:0] r;
        for (int ch = 0; ch < NC; ch++)
            r[ch] = m_rise[ch] || (repeat_en[ch] && m_level[ch] && m_tick &&
                    held[ch] >= DLY && ((held[ch] - DLY) % RATE == 0));
        return r;
    endfunction

    always @(negedge CLK) begin
        if (RST) begin
            check("model_level", 32'(level), 32'(m_level));
            check("model_rise",  32'(rise),  32'(m_rise));
            check("model_fall",  32'(fall),  32'(m_fall));
            check("model_press", 32'(press), 32'(model_press()));
            check("model_tick",  32'(tick),  32'(m_tick));
        end
    end

    typedef struct {
        logic [3:0] sw;
        int         cycles;
        logic [3:0] exp_level;
    } vec_t;

    vec_t vecs [6];

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_rise"},  32'(rise),  0);
        check({tag, "_fall"},  32'(fall),  0);
        check({tag, "_press"}, 32'(press), 0);
        check({tag, "_tick"},  32'(tick),  0);
    endtask

    int k, cnt_a, cnt_b, act;
    int pq [$];

    initial begin
        vecs[0] = '{4'b1000, 20, 4'b0000};
        vecs[1] = '{4'b1001, 20, 4'b0001};
        vecs[2] = '{4'b1011, 20, 4'b0011};
        vecs[3] = '{4'b0111, 20, 4'b1111};
        vecs[4] = '{4'b0010, 20, 4'b1010};
        vecs[5] = '{4'b1000, 20, 4'b0000};

        RST = 1'b0; sw_in = 4'b1000; repeat_en = '0;
        #1 check_zero("reset");
        @(negedge CLK) RST = 1'b1;

        for (k = 1; k <= 20; k++) begin step(1); if (tick) break; end
        check("first_tick_edge", k, PER);
        step(20);
        check("idle_inverted_ch3", 32'(level), 0);

        foreach (vecs[i]) begin
            sw_in = vecs[i].sw;
            step(vecs[i].cycles);
            check("vec_level", 32'(level), 32'(vecs[i].exp_level));
        end

        // Clean press on channel 0
        sw_in[0] = 1'b1;
        for (k = 1; k <= 30; k++) begin step(1); if (level[0]) break; end
        check("press_latency_in_range", 32'(k >= 11 && k <= 14), 1);
        check("press_rise",  32'(rise),  4'b0001);
        check("press_press", 32'(press), 4'b0001);
        step(1);
        check("press_rise_one_cycle", 32'(rise | press), 0);
        sw_in[0] = 1'b0;
        step(20);
        check("press_released", 32'(level), 0);

        // Bounce on channel 1
        cnt_a = 0; act = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) sw_in[1] = ~sw_in[1];
            step(1);
            act |= level[1];
            cnt_a += rise[1];
        end
        sw_in[1] = 1'b1;
        for (int c = 0; c < 30; c++) begin step(1); cnt_a += rise[1]; end
        check("bounce_level_quiet", act, 0);
        check("bounce_rise_count", cnt_a, 1);
        check("bounce_level_final", 32'(level[1]), 1);
        sw_in[1] = 1'b0;
        step(20);

        // Short glitch on channel 2
        sw_in[2] = 1'b1;
        step(2);
        sw_in[2] = 1'b0;
        act = 0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            act |= level[2] | rise[2] | fall[2] | press[2];
        end
        check("glitch_no_activity", act, 0);

        // Auto-repeat on channel 0
        repeat_en[0] = 1'b1;
        sw_in[0] = 1'b1;
        for (k = 1; k <= 30; k++) begin step(1); if (rise[0]) break; end
        check("repeat_rise_press", 32'(press[0]), 1);
        pq.delete();
        for (int c = 1; c <= 160; c++) begin step(1); if (press[0]) pq.push_back(c); end
        check("repeat_count", pq.size(), 18);
        check("repeat_first_gap", (pq.size() > 0) ? pq[0] : -1, 23);
        check("repeat_second_gap", (pq.size() > 1) ? pq[1] : -1, 31);
        repeat_en[0] = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 40; c++) begin step(1); cnt_a += press[0]; end
        check("repeat_disabled", cnt_a, 0);
        repeat_en[0] = 1'b1;
        step(16);
        sw_in[0] = 1'b0; repeat_en[0] = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 30; c++) begin step(1); cnt_a += fall[0]; cnt_b += press[0]; end
        check("release_fall_count", cnt_a, 1);
        check("release_no_press", cnt_b, 0);

        // Simultaneous edges on channels 0 and 3 (ch3 is active-low)
        sw_in = 4'b0001;
        for (k = 1; k <= 30; k++) begin step(1); if (rise != 0) break; end
        check("simul_rise", 32'(rise), 4'b1001);
        check("simul_press", 32'(press), 4'b1001);
        sw_in = 4'b1000;
        for (k = 1; k <= 30; k++) begin step(1); if (fall != 0) break; end
        check("simul_fall", 32'(fall), 4'b1001);
        step(10);

        // Async reset during a rise pulse
        sw_in[0] = 1'b1;
        for (k = 1; k <= 30; k++) begin step(1); if (rise[0]) break; end
        check("pre_reset_rise", 32'(rise[0]), 1);
        #2 RST = 1'b0;
        #1 check_zero("async_rst_rise");
        @(negedge CLK) RST = 1'b1;
        for (k = 1; k <= 20; k++) begin step(1); if (tick) break; end
        check("rst_first_tick", k, PER);
        for (k = PER + 1; k <= 30; k++) begin step(1); if (level[0]) break; end
        check("rst_redebounce_edge", k, 13);

        // Async reset while repeating
        repeat_en[0] = 1'b1;
        step(40);
        for (k = 1; k <= 40; k++) begin step(1); if (press[0]) break; end
        check("pre_reset_repeat", 32'(press[0]), 1);
        #2 RST = 1'b0;
        #1 check_zero("async_rst_repeat");
        @(negedge CLK) RST = 1'b1;
        step(20);

        // Random stimulus, checked continuously against the model
        for (int i = 0; i < 80; i++) begin
            sw_in     = 4'($urandom);
            repeat_en = 4'($urandom);
            step($urandom_range(1, 60));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_debounce_multi.md
Name: sw_debounce_multi

Overview:
Multi-channel successor to the single-switch debouncer and one-shot pulse generator.
- Synchronises N_CH raw switch inputs and debounces each one with a consecutive-sample stability counter driven by a shared sample-tick prescaler.
- Provides a per-channel debounced level, rise/fall one-shot pulses, and an optional auto-repeat press pulse for held keys.
- Sits between board pushbuttons/DIP switches and the CPU clock-step and input-port logic.

Parameters:
N_CH, 4, number of independent switch channels
PERIOD, 65536, CLK cycles per sample tick (>=2)
STABLE, 3, consecutive differing samples needed to flip a level (>=1)
REPEAT_DLY, 50, ticks a level must stay high before the first repeat press
REPEAT_RATE, 10, ticks between subsequent repeat presses (>=1)
INVERT, 0, N_CH-bit mask; bit i=1 means channel i is active-low at the pin

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
sw_in  in  N_CH  raw switch pins, asynchronous to CLK
repeat_en  in  N_CH  per-channel auto-repeat enable
level  out  N_CH  debounced level (1 = pressed, after INVERT)
rise  out  N_CH  one-CLK pulse on debounced 0->1
fall  out  N_CH  one-CLK pulse on debounced 1->0
press  out  N_CH  one-CLK pulse: rise OR auto-repeat event
tick  out  1  one-CLK sample strobe, exported for test/reuse

Behaviour:
- Reset: async on RST=0; all outputs, synchronisers, prescaler, and per-channel counters are 0. This holds mid-operation, including in a cycle where a pulse is asserted. Release is sampled normally on CLK.
- Synchroniser: s1 <= sw_in ^ INVERT; s2 <= s1. Only s2 feeds the debounce logic.
- Prescaler: pcnt counts 0..PERIOD-1 and wraps to 0. The tick register is 1 for exactly one cycle, on the cycle after pcnt == PERIOD-1. First tick: CLK edge PERIOD after reset release.
- Per channel, on a tick cycle only:
  - s2 != level: scnt += 1. If scnt+1 == STABLE: level <= ~level, scnt <= 0.
  - s2 == level: scnt <= 0 (any agreeing sample restarts the count).
  - Result: a glitch shorter than one tick period never toggles level when STABLE >= 2.
- scnt width: clog2(STABLE+1). It never exceeds STABLE-1.
- rise/fall are registered together with level. They are high in the same cycle level first shows its new value, for exactly one cycle. rise and fall are never high together on one channel.
- Latency from a clean edge at the pin to level: 2 sync cycles plus between (STABLE-1)*PERIOD+1 and STABLE*PERIOD cycles.
- Auto-repeat, per channel:
  - hcnt clears on rise and increments on each tick while level=1; it saturates rather than wraps.
  - press = rise, OR (repeat_en & level & tick & hcnt == REPEAT_DLY), OR (same with hcnt > REPEAT_DLY and (hcnt-REPEAT_DLY) % REPEAT_RATE == 0).
  - Implement the modulus as a reload down-counter; no divider.
  - hcnt saturation value must exceed REPEAT_DLY, so repeats continue indefinitely.
- repeat_en may change at any time. A deassert suppresses further repeats immediately. A reassert while held resumes on the existing hcnt schedule.
- level falling clears hcnt and the rate counter. No press occurs on fall.
- Channels are fully independent; simultaneous transitions on several channels pulse their bits in the same cycle.
- Multi-bit counters wrap or saturate only as stated. No combinational path from sw_in to any output.

Decomposition:
- Package sw_pkg: clog2 helper function, default constants (PERIOD, STABLE, REPEAT_DLY, REPEAT_RATE), and widths derived from them.
- Sub-module sw_debounce_ch: one channel's synchroniser, scnt, level, rise/fall edge, hcnt, and repeat counter. Inputs: CLK, RST, tick, raw bit, invert bit, repeat_en bit.
- Top level: shared prescaler plus a generate loop of N_CH instances.

Test Plan:
Use PERIOD=4, STABLE=3, REPEAT_DLY=5, REPEAT_RATE=2, N_CH=4, INVERT=4'b1000.
- Clean press: sw_in[0] 0->1 and held. Expect level[0]=1 within 2+12 CLK; rise[0] and press[0] high exactly 1 cycle, same cycle as level; other channels stay 0.
- Bounce: sw_in[1] toggles 1/0 every 3 CLK for 40 CLK, then stays 1. Expect level[1] stays 0 during bouncing and only rises after 3 consecutive high ticks; exactly one rise pulse.
- Glitch: sw_in[2] high for 2 CLK, then low. Expect no level, rise, fall, or press activity.
- Auto-repeat: repeat_en[0]=1, sw_in[0] held 1 for 40 ticks. Expect press at rise, then at hold ticks 5, 7, 9, ...; no repeats with repeat_en=0; fall[0] single pulse on release.
- Invert and simultaneous events: sw_in[3] held 1 from reset gives level[3]=0; driving it 0 gives rise[3]. Channels 0 and 3 switched in the same cycle pulse in the same cycle.
- Async reset mid-operation: RST=0 during a rise pulse and during repeating. Expect all outputs 0 immediately, without a CLK edge; after release, first tick at PERIOD edges and level re-debounces from 0.
